inst_fetch_queue: RTL and testbench

Instruction prefetch stage sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake. It buffers returned words with their PC+4 in a small FIFO and presents one instruction per cycle to IF/ID. Branch, jump and jr redirects from the MEM stage flush the queue and discard any in-flight stale read.

---
 rtl/inst_fetch_queue_pkg.sv | 21 ++
 rtl/inst_fetch_queue_fetch_fifo.sv | 66 ++++++
 rtl/inst_fetch_queue.sv | 140 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: fetch FSM states,
// the NOP presented on an empty queue, the default queue depth and a
// word-alignment helper for redirect targets.
package inst_fetch_queue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no request outstanding
        FETCH = 2'd1,   // request at fetch_pc outstanding
        DROP  = 2'd2    // stale request outstanding, its data is discarded
    } fetch_state_t;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam int          DEFAULT_DEPTH = 4;

    // Redirect targets are word addresses; the two low bits are forced to zero.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Synchronous FIFO holding {pc_plus4, instr} entries for the prefetch queue.
// Flush clears pointers and occupancy on the same edge and overrides any push
// or pop in that cycle. Pop on empty and push on full are ignored.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic                       o_head_valid,
    output logic [WIDTH-1:0]           o_head_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && (r_count != FULL_COUNT);
    assign w_do_pop  = i_pop  && (r_count != CW'(0));

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge Clk) begin
        if (Reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful between head and tail, so no reset.
    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[r_tail] <= i_push_data;
        end
    end

    assign o_head_valid = (r_count != CW'(0));
    assign o_head_data  = r_mem[r_head];
    assign o_count      = r_count;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch stage feeding the IF/ID register. Owns the fetch PC,
// issues one word read at a time over a req/ack handshake, queues returned
// words with their PC+4 and presents the head to IF/ID. MEM-stage redirects
// flush the queue; a read still in flight at redirect time is completed in
// DROP and its data thrown away.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  w_fetch_pc_next;
    logic [31:0]  r_drop_addr;
    logic [31:0]  w_drop_addr_next;

    logic          w_ack;
    logic          w_pop;
    logic          w_push;
    logic          w_flush;
    logic [31:0]   w_pc_plus4;
    logic [31:0]   w_redirect_pc;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_after_push;
    logic          w_head_valid;
    logic [63:0]   w_head_data;

    // An ack only counts while a request is actually outstanding.
    assign w_ack         = mem_ack && mem_req;
    // A redirect kills the head in the same cycle, so it must not be consumed.
    assign w_pop         = w_head_valid && !stall && !redirect;
    assign w_pc_plus4    = r_fetch_pc + 32'd4;
    assign w_redirect_pc = align_word(redirect_pc);
    // Occupancy after a push this cycle, used to decide whether to keep fetching.
    assign w_count_after_push = w_count + CW'(1) - CW'(w_pop);

    // Fetch FSM next-state, next fetch PC and queue push/flush decisions.
    always_comb begin
        w_state_next     = r_state;
        w_fetch_pc_next  = r_fetch_pc;
        w_drop_addr_next = r_drop_addr;
        w_push           = 1'b0;
        w_flush          = 1'b0;
        case (r_state)
            IDLE: begin
                if (redirect) begin
                    w_flush         = 1'b1;
                    w_fetch_pc_next = w_redirect_pc;
                    w_state_next    = FETCH;
                end else if (w_count < FULL_COUNT) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                if (redirect) begin
                    w_flush         = 1'b1;
                    w_fetch_pc_next = w_redirect_pc;
                    if (!w_ack) begin
                        // Read still in flight: finish it at its old address, then discard.
                        w_drop_addr_next = r_fetch_pc;
                        w_state_next     = DROP;
                    end
                end else if (w_ack) begin
                    w_push          = 1'b1;
                    w_fetch_pc_next = w_pc_plus4;
                    if (w_count_after_push >= FULL_COUNT) begin
                        w_state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    w_flush         = 1'b1;
                    w_fetch_pc_next = w_redirect_pc;
                end
                if (w_ack) begin
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Fetch FSM state, fetch PC and stale-request address registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else begin
            r_state     <= w_state_next;
            r_fetch_pc  <= w_fetch_pc_next;
            r_drop_addr <= w_drop_addr_next;
        end
    end

    assign mem_req  = (r_state != IDLE);
    assign mem_addr = (r_state == DROP) ? r_drop_addr : r_fetch_pc;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fetch_fifo (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_push       (w_push),
        .i_push_data  ({w_pc_plus4, mem_rdata}),
        .i_pop        (w_pop),
        .i_flush      (w_flush),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head_data),
        .o_count      (w_count)
    );

    assign if_valid    = w_head_valid;
    assign if_instr    = w_head_valid ? w_head_data[31:0]  : NOP_INSTR;
    assign if_pc_plus4 = w_head_valid ? w_head_data[63:32] : 32'h0000_0000;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: directed scenarios against a behavioural
// instruction memory that returns the request address as data, with an
// independent scoreboard monitor checking every word IF/ID consumes.
module tb_inst_fetch_queue;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;

    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_q [$];

    int   lat = 0;
    logic mem_en = 1'b1;
    int   wait_cnt = 0;

    inst_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc_plus4 (if_pc_plus4)
    );

    always #5 Clk = ~Clk;

    // Memory model: ack once the request has waited lat cycles; data = address.
    assign mem_ack   = mem_req && mem_en && (wait_cnt >= lat);
    assign mem_rdata = mem_addr;

    always @(posedge Clk) begin
        if (Reset || !mem_req || mem_ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
    end

    // Scoreboard monitor: every consumed head must match the next expected entry.
    initial begin
        logic [63:0] exp_e;
        forever begin
            @(negedge Clk);
            if (!Reset && if_valid && !stall && !redirect) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got pc4=%h instr=%h, required no consumed entry",
                             if_pc_plus4, if_instr);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({if_pc_plus4, if_instr} !== exp_e) begin
                        errors++;
                        $display("FAIL pop_entry: got pc4=%h instr=%h, required pc4=%h instr=%h",
                                 if_pc_plus4, if_instr, exp_e[63:32], exp_e[31:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic pop_one(input logic [31:0] pc4, input logic [31:0] instr);
        exp_q.push_back({pc4, instr});
        stall = 1'b0;
        tick();
        stall = 1'b1;
    endtask

    initial begin
        Reset       = 1'b1;
        stall       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();

        // Reset values
        chk("rst_mem_req",  {31'b0, mem_req},  32'h0);
        chk("rst_mem_addr", mem_addr,          32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_if_instr", if_instr,          32'h0);
        chk("rst_if_pc4",   if_pc_plus4,       32'h0);

        // Streaming with zero-wait memory: one instruction per cycle
        stall = 1'b0;
        for (int a = 0; a <= 16; a += 4) exp_q.push_back({32'(a + 4), 32'(a)});
        Reset = 1'b0;
        tick();
        chk("s1_first_req",  {31'b0, mem_req},  32'h1);
        chk("s1_first_addr", mem_addr,          32'h0);
        chk("s1_not_valid",  {31'b0, if_valid}, 32'h0);
        for (int k = 2; k <= 7; k++) begin
            tick();
            chk("s1_valid", {31'b0, if_valid}, 32'h1);
            chk("s1_instr", if_instr,          32'(4 * (k - 2)));
            chk("s1_pc4",   if_pc_plus4,       32'(4 * (k - 1)));
        end
        stall = 1'b1;
        tick();
        chk("s1_drained", 32'(exp_q.size()), 32'h0);

        // Stall fills the queue, fetching pauses at 16, release drains in order
        do_reset();
        for (int k = 1; k <= 6; k++) tick();
        chk("s2_full_req",  {31'b0, mem_req}, 32'h0);
        chk("s2_full_addr", mem_addr,         32'h10);
        chk("s2_head",      if_instr,         32'h0);
        for (int a = 0; a <= 12; a += 4) exp_q.push_back({32'(a + 4), 32'(a)});
        stall = 1'b0;
        tick();
        chk("s2_idle_after_pop", {31'b0, mem_req}, 32'h0);
        chk("s2_head_4",         if_instr,         32'h4);
        tick();
        chk("s2_refetch_req",  {31'b0, mem_req}, 32'h1);
        chk("s2_refetch_addr", mem_addr,         32'h10);
        tick();
        chk("s2_head_12", if_instr, 32'hC);
        tick();
        stall = 1'b1;
        tick();
        chk("s2_drained", 32'(exp_q.size()), 32'h0);

        // Slow memory, redirect while a read is in flight; last redirect wins
        lat = 3;
        do_reset();
        for (int k = 1; k <= 9; k++) tick();
        chk("s3_req_addr", mem_addr, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h100;
        chk("s3_drop_req",   {31'b0, mem_req},  32'h1);
        chk("s3_drop_addr",  mem_addr,          32'h8);
        chk("s3_flushed",    {31'b0, if_valid}, 32'h0);
        tick();
        redirect = 1'b0;
        chk("s3_drop_addr2", mem_addr, 32'h8);
        tick();
        chk("s3_drop_addr3", mem_addr, 32'h8);
        tick();
        chk("s3_target_req",  {31'b0, mem_req},  32'h1);
        chk("s3_target_addr", mem_addr,          32'h100);
        chk("s3_no_stale",    {31'b0, if_valid}, 32'h0);
        for (int k = 0; k < 4; k++) tick();
        chk("s3_target_valid", {31'b0, if_valid}, 32'h1);
        pop_one(32'h104, 32'h100);

        // Redirect and ack in the same cycle with a pop pending
        lat = 0;
        do_reset();
        tick();
        tick();
        tick();
        chk("s4_head", if_instr, 32'h0);
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        tick();
        redirect = 1'b0;
        stall    = 1'b1;
        chk("s4_empty",    {31'b0, if_valid}, 32'h0);
        chk("s4_req_addr", mem_addr,          32'h200);
        tick();
        chk("s4_valid", {31'b0, if_valid}, 32'h1);
        chk("s4_instr", if_instr,          32'h200);
        chk("s4_pc4",   if_pc_plus4,       32'h204);
        pop_one(32'h204, 32'h200);

        // PC+4 wraps at the top of the address space
        do_reset();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("s5_addr_top", mem_addr, 32'hFFFF_FFFC);
        tick();
        chk("s5_instr",    if_instr,    32'hFFFF_FFFC);
        chk("s5_pc4_wrap", if_pc_plus4, 32'h0);
        chk("s5_next_addr", mem_addr,   32'h0);
        pop_one(32'h0, 32'hFFFF_FFFC);

        // Reset while in DROP with an ack that never arrives
        do_reset();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        mem_en   = 1'b0;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("s6_drop_req",  {31'b0, mem_req}, 32'h1);
        chk("s6_drop_addr", mem_addr,         32'h80);
        tick();
        chk("s6_drop_hold", mem_addr, 32'h80);
        Reset = 1'b1;
        tick();
        chk("s6_rst_req",   {31'b0, mem_req},  32'h0);
        chk("s6_rst_addr",  mem_addr,          32'h0);
        chk("s6_rst_valid", {31'b0, if_valid}, 32'h0);
        chk("s6_rst_instr", if_instr,          32'h0);
        chk("s6_rst_pc4",   if_pc_plus4,       32'h0);
        Reset  = 1'b0;
        mem_en = 1'b1;
        tick();
        chk("s6_refetch_req",  {31'b0, mem_req}, 32'h1);
        chk("s6_refetch_addr", mem_addr,         32'h0);
        tick();
        chk("s6_refetch_valid", {31'b0, if_valid}, 32'h1);
        pop_one(32'h4, 32'h0);

        tick();
        tick();
        chk("final_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
